// File: rtl/accel_loader.sv
// Streaming job loader: parses a 9-word header into configuration registers,
// writes image and filter payloads to memory, then runs the accelerator.
module accel_loader #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] interface_write_addr,
  output logic [DATA_WIDTH-1:0] interface_write_data,
  output logic                  interface_write_en,
  output logic [7:0]            image_dim,
  output logic [8:0]            image_depth,
  output logic [15:0]           image_memory_offset,
  output logic [15:0]           filter_memory_offset,
  output logic [15:0]           output_memory_offset,
  output logic [1:0]            filter_halfsize,
  output logic [2:0]            filter_stride,
  output logic [12:0]           filter_length,
  output logic [17:0]           filter_bias,
  output logic                  accel_rst,
  input  logic                  accel_done,
  output logic                  loader_done,
  input  logic                  loader_ack
);

  typedef enum logic [2:0] {HEADER, IMAGE, FILTER, LAUNCH, RUN, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  hdr_cnt, hdr_cnt_next;
  logic [15:0] pay_cnt, pay_cnt_next;
  logic [15:0] image_count;
  logic [17:0] hdr_word;
  logic [15:0] payload_base;
  logic [ADDR_WIDTH-1:0] payload_addr;
  logic        accept;
  logic        payload_state;

  // Header fields are taken from an 18-bit view of the stream word.
  generate
    if (DATA_WIDTH >= 18) begin : g_wide
      assign hdr_word = in_data[17:0];
    end else begin : g_narrow
      assign hdr_word = {{(18 - DATA_WIDTH){1'b0}}, in_data};
    end
  endgenerate

  assign in_ready      = !rst && (state == HEADER || state == IMAGE || state == FILTER);
  assign accept        = in_valid && in_ready;
  assign payload_state = (state == IMAGE) || (state == FILTER);
  assign payload_base  = (state == IMAGE) ? image_memory_offset : filter_memory_offset;
  assign payload_addr  = ADDR_WIDTH'(payload_base) + ADDR_WIDTH'(pay_cnt);
  assign accel_rst     = (state != RUN);
  assign loader_done   = (state == DONE);

  always_comb begin
    state_next   = state;
    hdr_cnt_next = hdr_cnt;
    pay_cnt_next = pay_cnt;
    case (state)
      HEADER: if (accept) begin
        if (hdr_cnt == 4'd8) begin
          hdr_cnt_next = 4'd0;
          pay_cnt_next = 16'd0;
          // image_count is still being latched, so look at the live word
          if (hdr_word[15:0] != 16'd0)   state_next = IMAGE;
          else if (filter_length != 13'd0) state_next = FILTER;
          else                             state_next = LAUNCH;
        end else begin
          hdr_cnt_next = hdr_cnt + 4'd1;
        end
      end
      IMAGE: if (accept) begin
        if (pay_cnt == image_count - 16'd1) begin
          pay_cnt_next = 16'd0;
          state_next   = (filter_length != 13'd0) ? FILTER : LAUNCH;
        end else begin
          pay_cnt_next = pay_cnt + 16'd1;
        end
      end
      FILTER: if (accept) begin
        if (pay_cnt == {3'b000, filter_length} - 16'd1) begin
          pay_cnt_next = 16'd0;
          state_next   = LAUNCH;
        end else begin
          pay_cnt_next = pay_cnt + 16'd1;
        end
      end
      LAUNCH: state_next = RUN;
      RUN:    if (accel_done) state_next = DONE;
      DONE:   if (loader_ack) begin
        state_next   = HEADER;
        hdr_cnt_next = 4'd0;
      end
      default: state_next = HEADER;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= HEADER;
      hdr_cnt              <= 4'd0;
      pay_cnt              <= 16'd0;
      image_count          <= 16'd0;
      image_dim            <= 8'd0;
      image_depth          <= 9'd0;
      image_memory_offset  <= 16'd0;
      filter_memory_offset <= 16'd0;
      output_memory_offset <= 16'd0;
      filter_halfsize      <= 2'd0;
      filter_stride        <= 3'd0;
      filter_length        <= 13'd0;
      filter_bias          <= 18'd0;
      interface_write_en   <= 1'b0;
      interface_write_addr <= '0;
      interface_write_data <= '0;
    end else begin
      state              <= state_next;
      hdr_cnt            <= hdr_cnt_next;
      pay_cnt            <= pay_cnt_next;
      interface_write_en <= accept && payload_state;
      if (accept && payload_state) begin
        interface_write_addr <= payload_addr;
        interface_write_data <= in_data;
      end
      if (accept && state == HEADER) begin
        case (hdr_cnt)
          4'd0: image_dim            <= hdr_word[7:0];
          4'd1: image_depth          <= hdr_word[8:0];
          4'd2: image_memory_offset  <= hdr_word[15:0];
          4'd3: filter_memory_offset <= hdr_word[15:0];
          4'd4: output_memory_offset <= hdr_word[15:0];
          4'd5: begin
            filter_halfsize <= hdr_word[1:0];
            filter_stride   <= hdr_word[4:2];
          end
          4'd6: filter_length <= hdr_word[12:0];
          4'd7: filter_bias   <= hdr_word[17:0];
          4'd8: image_count   <= hdr_word[15:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_accel_loader.sv
// Self-checking bench for accel_loader: table-driven jobs, random jobs,
// a mid-job reset, and a negedge monitor holding a word-level reference model.
module tb_accel_loader;
  localparam int DW = 18;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic [7:0]    image_dim;
  logic [8:0]    image_depth;
  logic [15:0]   image_off, filter_off, output_off;
  logic [1:0]    halfsize;
  logic [2:0]    stride;
  logic [12:0]   flen;
  logic [17:0]   bias;
  logic          accel_rst;
  logic          accel_done;
  logic          loader_done;
  logic          loader_ack;

  always #5 clk = ~clk;

  accel_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .interface_write_addr(wr_addr), .interface_write_data(wr_data), .interface_write_en(wr_en),
    .image_dim(image_dim), .image_depth(image_depth), .image_memory_offset(image_off),
    .filter_memory_offset(filter_off), .output_memory_offset(output_off),
    .filter_halfsize(halfsize), .filter_stride(stride), .filter_length(flen), .filter_bias(bias),
    .accel_rst(accel_rst), .accel_done(accel_done), .loader_done(loader_done), .loader_ack(loader_ack)
  );

  int errors = 0;
  int checks = 0;
  int wr_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counts accepted words of the job and derives the
  // expected memory write (address, data) of each payload word.
  typedef enum {P_LOAD, P_LAUNCH, P_RUN, P_DONE} phase_t;
  initial begin
    phase_t      ph = P_LOAD;
    int          k = 0, ic = 0, fl = 0, idx;
    logic [17:0] hdr [9];
    logic        pend = 1'b0, pend_n;
    logic [15:0] pend_addr = '0;
    logic [17:0] pend_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_accel_rst", accel_rst, 1'b1);
        ph = P_LOAD; k = 0; pend = 1'b0;
      end else begin
        chk("wr_en", wr_en, pend);
        if (wr_en) wr_count++;
        if (pend) begin
          chk("wr_addr", wr_addr, pend_addr);
          chk("wr_data", wr_data, pend_data);
        end
        chk("in_ready", in_ready, ph == P_LOAD);
        chk("accel_rst", accel_rst, ph != P_RUN);
        chk("loader_done", loader_done, ph == P_DONE);
        pend_n = 1'b0;
        case (ph)
          P_LOAD: if (in_valid) begin
            if (k < 9) hdr[k] = in_data;
            else begin
              idx = k - 9;
              pend_addr = (idx < ic) ? 16'(hdr[2][15:0] + idx) : 16'(hdr[3][15:0] + idx - ic);
              pend_data = in_data;
              pend_n = 1'b1;
            end
            k++;
            if (k == 9) begin ic = int'(hdr[8][15:0]); fl = int'(hdr[6][12:0]); end
            if (k >= 9 && k == 9 + ic + fl) ph = P_LAUNCH;
          end
          P_LAUNCH: ph = P_RUN;
          P_RUN:    if (accel_done) ph = P_DONE;
          P_DONE:   if (loader_ack) begin ph = P_LOAD; k = 0; end
          default:  ph = P_LOAD;
        endcase
        pend = pend_n;
      end
    end
  end

  typedef struct {
    logic [8:0][17:0] h;
    int gap, exp_writes;
    logic [7:0] dim; logic [8:0] depth;
    logic [15:0] ioff, foff, ooff;
    logic [1:0] half; logic [2:0] str; logic [12:0] fl; logic [17:0] bias;
  } job_t;

  function automatic job_t mk(input logic [17:0] h0, h1, h2, h3, h4, h5, h6, h7, h8,
                              input int gap, input int nw, input logic [7:0] dim, input logic [8:0] depth,
                              input logic [15:0] ioff, foff, ooff, input logic [1:0] half,
                              input logic [2:0] str, input logic [12:0] fl, input logic [17:0] bias);
    job_t j;
    j.h[0] = h0; j.h[1] = h1; j.h[2] = h2; j.h[3] = h3; j.h[4] = h4;
    j.h[5] = h5; j.h[6] = h6; j.h[7] = h7; j.h[8] = h8;
    j.gap = gap; j.exp_writes = nw; j.dim = dim; j.depth = depth;
    j.ioff = ioff; j.foff = foff; j.ooff = ooff; j.half = half; j.str = str; j.fl = fl; j.bias = bias;
    return j;
  endfunction

  // gap 0: back-to-back, 1: one idle cycle before each word, 2: random idles.
  task automatic send_word(input logic [17:0] d, input int gap);
    int idle;
    logic acc;
    idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (idle) begin
      in_valid = 1'b0; accel_done = 1'($urandom); loader_ack = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = d; accel_done = 1'($urandom); loader_ack = 1'($urandom);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      if (t == 19) begin errors++; checks++; $display("FAIL accept_timeout: word %0h never accepted", d); end
    end
    in_valid = 1'b0; accel_done = 1'b0; loader_ack = 1'b0;
  endtask

  task automatic run_job(input job_t j);
    int w0, n;
    logic [17:0] d;
    w0 = wr_count;
    for (int i = 0; i < 9; i++) send_word(j.h[i], j.gap);
    n = int'(j.h[8][15:0]) + int'(j.h[6][12:0]);
    for (int i = 0; i < n; i++) begin d = 18'($urandom); send_word(d, j.gap); end
    chk("launch_accel_rst", accel_rst, 1'b1);
    chk("launch_in_ready", in_ready, 1'b0);
    chk("launch_wr_en", wr_en, n > 0);
    @(posedge clk); #1;
    chk("run_accel_rst", accel_rst, 1'b0);
    chk("write_count", wr_count - w0, j.exp_writes);
    loader_ack = 1'b1;
    repeat (int'($urandom_range(1, 3))) begin @(posedge clk); #1; end
    chk("run_ignores_ack", loader_done, 1'b0);
    loader_ack = 1'b0; accel_done = 1'b1;
    @(posedge clk); #1;
    accel_done = 1'b0;
    chk("done_loader_done", loader_done, 1'b1);
    chk("done_accel_rst", accel_rst, 1'b1);
    chk("cfg_dim", image_dim, j.dim);
    chk("cfg_depth", image_depth, j.depth);
    chk("cfg_ioff", image_off, j.ioff);
    chk("cfg_foff", filter_off, j.foff);
    chk("cfg_ooff", output_off, j.ooff);
    chk("cfg_half", halfsize, j.half);
    chk("cfg_stride", stride, j.str);
    chk("cfg_flen", flen, j.fl);
    chk("cfg_bias", bias, j.bias);
    @(posedge clk); #1;
    chk("done_holds", loader_done, 1'b1);
    loader_ack = 1'b1;
    @(posedge clk); #1;
    loader_ack = 1'b0;
    chk("ack_loader_done", loader_done, 1'b0);
    chk("ack_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t jobs[6];
    job_t rj;
    jobs[0] = mk(4, 1, 'h100, 'h200, 'h300, 0, 9, 0, 16, 0, 25, 4, 1, 'h100, 'h200, 'h300, 0, 0, 9, 0);
    jobs[1] = mk(4, 1, 'h100, 'h200, 'h300, 'h0D, 9, 'h1234, 16, 1, 25, 4, 1, 'h100, 'h200, 'h300, 1, 3, 9, 'h1234);
    jobs[2] = mk(8, 3, 'h50, 'h400, 'h500, 'h06, 3, 'h3FFFF, 0, 2, 3, 8, 3, 'h50, 'h400, 'h500, 2, 1, 3, 'h3FFFF);
    jobs[3] = mk(2, 2, 'hFFFE, 'h10, 'h20, 'h1F, 0, 5, 4, 0, 4, 2, 2, 'hFFFE, 'h10, 'h20, 3, 7, 0, 5);
    jobs[4] = mk('h3FF12, 'h3FFFF, 'h3FFF0, 'h12345, 'h20007, 'h3FFFF, 'h3E005, 'h2ABCD, 'h30002,
                 2, 7, 'h12, 'h1FF, 'hFFF0, 'h2345, 'h0007, 3, 7, 5, 'h2ABCD);
    jobs[5] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; accel_done = 1'b0; loader_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_accel_rst", accel_rst, 1'b1);
    chk("reset_loader_done", loader_done, 1'b0);
    chk("reset_wr_en", wr_en, 1'b0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_dim", image_dim, 0);
    chk("reset_bias", bias, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_in_ready", in_ready, 1'b1);

    for (int r = 0; r < 6; r++) run_job(jobs[r]);

    // Abort during the filter payload at j=2 (pending write of j=1 visible).
    rj = mk(5, 1, 'h700, 'h800, 'h900, 0, 6, 1, 2, 0, 0, 5, 1, 'h700, 'h800, 'h900, 0, 0, 6, 1);
    for (int i = 0; i < 9; i++) send_word(rj.h[i], 0);
    for (int i = 0; i < 4; i++) send_word(18'($urandom), 0);
    chk("pre_abort_wr_en", wr_en, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_wr_en", wr_en, 1'b0);
    chk("abort_wr_addr", wr_addr, 0);
    chk("abort_wr_data", wr_data, 0);
    chk("abort_in_ready", in_ready, 1'b0);
    chk("abort_accel_rst", accel_rst, 1'b1);
    chk("abort_loader_done", loader_done, 1'b0);
    chk("abort_ioff", image_off, 0);
    chk("abort_flen", flen, 0);
    in_valid = 1'b1; in_data = 18'h155;
    repeat (2) begin @(posedge clk); #1; chk("abort_hold_wr_en", wr_en, 1'b0); end
    in_valid = 1'b0;
    rst = 1'b0;
    run_job(jobs[0]);

    for (int r = 0; r < 5; r++) begin
      logic [17:0] w[9];
      for (int i = 0; i < 9; i++) w[i] = 18'($urandom);
      w[6] = {5'($urandom), 13'($urandom_range(0, 12))};
      w[8] = {2'($urandom), 16'($urandom_range(0, 20))};
      rj = mk(w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7], w[8], 2,
              int'(w[8][15:0]) + int'(w[6][12:0]), w[0][7:0], w[1][8:0], w[2][15:0], w[3][15:0],
              w[4][15:0], w[5][1:0], w[5][4:2], w[6][12:0], w[7]);
      run_job(rj);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/accel_loader.md
ACCEL_LOADER -- requirements
Module: accel_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18, the stream and memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, the memory address width.
REQ-003 SHALL have ports: clk  in  1  single clock, rising edge; all state changes on this edge.
REQ-004 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: in_data  in  DATA_WIDTH  stream word; in_valid  in  1  word present; in_ready  out  1  word accepted when in_valid & in_ready.
REQ-006 SHALL have ports: interface_write_addr  out  ADDR_WIDTH; interface_write_data  out  DATA_WIDTH; interface_write_en  out  1  memory write port.
REQ-007 SHALL have ports: image_dim out 8; image_depth out 9; image_memory_offset, filter_memory_offset, output_memory_offset out 16 each; filter_halfsize out 2; filter_stride out 3; filter_length out 13; filter_bias out 18. These are latched configuration outputs.
REQ-008 SHALL have ports: accel_rst  out  1  reset to accelerator; accel_done  in  1  accelerator finished.
REQ-009 SHALL have ports: loader_done  out  1  job complete, level; loader_ack  in  1  host clears done.

Function
REQ-010 SHALL implement the states HEADER, IMAGE, FILTER, LAUNCH, RUN and DONE; the reset state SHALL be HEADER.
REQ-011 In HEADER, SHALL accept 9 words, counted 0..8, into: H0 image_dim[7:0]; H1 image_depth[8:0]; H2 image_offset[15:0]; H3 filter_offset; H4 output_offset; H5 halfsize=bits[1:0], stride=bits[4:2]; H6 filter_length[12:0]; H7 bias[17:0]; H8 image_count[15:0]. Unused high bits SHALL be ignored.
REQ-012 After H8 is accepted, SHALL go to IMAGE if image_count!=0, else to FILTER if filter_length!=0, else to LAUNCH.
REQ-013 In IMAGE, SHALL write accepted word i to image_offset+i, for i=0..image_count-1, then move to FILTER (or LAUNCH if filter_length==0).
REQ-014 In FILTER, SHALL write accepted word j to filter_offset+j, for j=0..filter_length-1, then move to LAUNCH.
REQ-015 Address sums SHALL wrap modulo 2^ADDR_WIDTH.
REQ-016 Writes SHALL be registered: a beat accepted in cycle N gives interface_write_en=1 with its addr/data in cycle N+1. interface_write_en SHALL be 0 in all other cycles.
REQ-017 in_ready SHALL be 1 in HEADER, IMAGE and FILTER, and 0 in LAUNCH, RUN and DONE.
REQ-018 Back-to-back beats SHALL be accepted at one per cycle with no bubbles; gaps in in_valid SHALL stall the counters only.
REQ-019 LAUNCH SHALL last exactly 1 cycle with accel_rst=1, so the last payload write commits before release, then move to RUN.
REQ-020 In RUN, accel_rst SHALL be 0. In all other states accel_rst SHALL be 1.
REQ-021 accel_done SHALL be ignored outside RUN. In RUN, accel_done=1 SHALL move the block to DONE on the next edge.
REQ-022 In DONE, loader_done SHALL be 1. loader_ack=1 SHALL return the block to HEADER and clear the header counter.
REQ-023 loader_done SHALL be 0 in every state except DONE; loader_ack outside DONE SHALL have no effect.
REQ-024 Configuration outputs SHALL update only when their header word is accepted, and SHALL otherwise hold through RUN and DONE.

Reset
REQ-025 On rst, asynchronously: state=HEADER; counters=0; all configuration outputs=0; interface_write_en=0; write addr/data=0; accel_rst=1; loader_done=0; in_ready=0 while rst is high.
REQ-026 rst asserted mid-operation in any state SHALL abandon the job; any pending registered write SHALL be dropped.

Verification
REQ-027 Header dim=4, depth=1, offsets 0x0100/0x0200/0x0300, image_count=16, filter_length=9, followed by 25 words -> 16 writes to 0x0100..0x010F and 9 writes to 0x0200..0x0208, each 1 cycle after acceptance; then LAUNCH; then accel_rst falls.
REQ-028 Payload with in_valid toggled every other cycle -> same addresses with no skipped or duplicated writes; in_ready stays 1 during payload.
REQ-029 image_count=0, filter_length=3 -> no image writes; filter writes to filter_offset+0..2; then LAUNCH.
REQ-030 image_offset=0xFFFE, image_count=4 -> writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-031 accel_done pulsed during IMAGE -> ignored. accel_done in RUN -> DONE next cycle, loader_done=1, accel_rst=1. loader_ack -> HEADER, and a second job loads correctly.
REQ-032 rst asserted during FILTER at j=2 -> all outputs take reset values immediately, no further writes, and a fresh header is accepted after release.
